// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - two-master fixed-priority bus arbiter, bus mux and read-data return mux
// Optional feature macro: ARB_TENURE_LIMIT_EN (adds MAX_TENURE and an M1 tenure limit)
module bus_arbiter_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
`ifdef ARB_TENURE_LIMIT_EN
  ,
  parameter int MAX_TENURE = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din,
  input  logic [4:0]        s_sel,
  input  logic [DATA_W-1:0] s0_dout,
  input  logic [DATA_W-1:0] s1_dout,
  input  logic [DATA_W-1:0] s2_dout,
  input  logic [DATA_W-1:0] s3_dout,
  input  logic [DATA_W-1:0] s4_dout,
  output logic [DATA_W-1:0] m_din,
  output logic              bus_err
);

  typedef enum logic {GRANT_M0 = 1'b0, GRANT_M1 = 1'b1} state_t;

  state_t     state;
  state_t     next_state;
  logic       acc;
  logic [4:0] sel_q;

`ifdef ARB_TENURE_LIMIT_EN
  localparam int TW = $clog2(MAX_TENURE + 1);
  logic [TW-1:0] tenure_q;
  logic          tenure_max;

  assign tenure_max = (tenure_q == TW'(MAX_TENURE - 1));

  // Count M1 busy cycles; restart on any handover, saturate at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tenure_q <= '0;
    end else if (state != next_state) begin
      tenure_q <= '0;
    end else if (state == GRANT_M1 && m1_req && !tenure_max) begin
      tenure_q <= tenure_q + 1'b1;
    end
  end
`endif

  // State register; reset parks the bus on M0 and drops any DMAC tenure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= GRANT_M0;
    end else begin
      state <= next_state;
    end
  end

  // Fixed-priority next state: M0 wins ties, M1 keeps the bus while requesting
  always_comb begin
    next_state = state;
    case (state)
      GRANT_M0: begin
        if (!m0_req && m1_req) next_state = GRANT_M1;
      end
      GRANT_M1: begin
        if (!m1_req) next_state = GRANT_M0;
`ifdef ARB_TENURE_LIMIT_EN
        else if (tenure_max && m0_req) next_state = GRANT_M0;
`endif
      end
      default: next_state = GRANT_M0;
    endcase
  end

  assign m0_grant = (state == GRANT_M0);
  assign m1_grant = (state == GRANT_M1);

  // Route the owner's address/data onto the bus; write strobe only when owner is active
  always_comb begin
    s_address = m0_address;
    s_din     = m0_dout;
    s_wr      = 1'b0;
    acc       = 1'b0;
    if (state == GRANT_M1) begin
      s_address = m1_address;
      s_din     = m1_dout;
      acc       = m1_req;
      s_wr      = m1_wr & m1_req;
    end else begin
      acc       = m0_req;
      s_wr      = m0_wr & m0_req;
    end
  end

  // Remember which slave a read targeted so its registered data returns next cycle; flag unmapped accesses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q   <= 5'b00000;
      bus_err <= 1'b0;
    end else begin
      sel_q   <= s_sel & {5{acc & ~s_wr}};
      bus_err <= acc & (s_sel == 5'b00000);
    end
  end

  // Return-data mux; anything other than a clean one-hot select yields zero
  always_comb begin
    m_din = '0;
    case (sel_q)
      5'b10000: m_din = s0_dout;
      5'b01000: m_din = s1_dout;
      5'b00100: m_din = s2_dout;
      5'b00010: m_din = s3_dout;
      5'b00001: m_din = s4_dout;
      default:  m_din = '0;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - directed self-checking bench for bus_arbiter_mux
module tb_bus_arbiter_mux;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_address, m1_address, s_address;
  logic [31:0] m0_dout, m1_dout, s_din, m_din;
  logic        m0_grant, m1_grant, s_wr, bus_err;
  logic [4:0]  s_sel;
  logic [31:0] s0_dout, s1_dout, s2_dout, s3_dout, s4_dout;

  int tests_run = 0;
  int tests_failed = 0;

  bus_arbiter_mux #(
    .DATA_W(32),
    .ADDR_W(16)
`ifdef ARB_TENURE_LIMIT_EN
    ,
    .MAX_TENURE(4)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_address(s_address), .s_wr(s_wr), .s_din(s_din),
    .s_sel(s_sel),
    .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout), .s3_dout(s3_dout), .s4_dout(s4_dout),
    .m_din(m_din), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_address = 16'h0000; m0_dout = 32'h0;
    m1_req = 0; m1_wr = 0; m1_address = 16'h0000; m1_dout = 32'h0;
    s_sel = 5'b00000;
    s0_dout = 32'hA5A5_0000; s1_dout = 32'hA5A5_0001; s2_dout = 32'hA5A5_0002;
    s3_dout = 32'hA5A5_0003; s4_dout = 32'hA5A5_0004;

    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_m0_grant", m0_grant, 1);
    check("rst_m1_grant", m1_grant, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_m_din", m_din, 0);

    // M1 read of 0x0210 from slave s2
    m1_req = 1; m1_wr = 0; m1_address = 16'h0210;
    tick();
    check("m1_grant_cyc1", m1_grant, 1);
    check("m0_grant_cyc1", m0_grant, 0);
    check("m1_s_address", s_address, 32'h0210);
    check("m1_s_wr_read", s_wr, 0);
    s_sel = 5'b00100;
    tick();
    check("m1_read_s2", m_din, 32'hA5A5_0002);
    check("m1_read_no_err", bus_err, 0);
    m1_req = 0; s_sel = 5'b00000;
    tick();
    check("m1_release_m0", m0_grant, 1);
    check("m1_release_mdin", m_din, 0);

    // Both request: M0 keeps the bus, reading s0
    m0_req = 1; m0_wr = 0; m0_address = 16'h0100; m1_req = 1; m1_address = 16'h0300;
    s_sel = 5'b10000;
    tick();
    check("tie_m0_hold1", m0_grant, 1);
    check("tie_m0_read_s0", m_din, 32'hA5A5_0000);
    check("tie_s_address", s_address, 32'h0100);
    tick();
    check("tie_m0_hold2", m0_grant, 1);
    m0_req = 0;
    tick();
    check("handover_m1", m1_grant, 1);
    check("handover_bubble_mdin", m_din, 0);
    m0_req = 1; s_sel = 5'b00001;
`ifdef ARB_TENURE_LIMIT_EN
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("tenure_m1_cyc%0d", i), m1_grant, 1);
    end
    tick();
    check("tenure_force_m0", m0_grant, 1);
    m0_req = 0; m1_req = 0; s_sel = 5'b00000;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("no_preempt_%0d", i), m1_grant, 1);
    end
    check("m1_read_s4", m_din, 32'hA5A5_0004);
    m1_req = 0; s_sel = 5'b00000;
    tick();
    check("m1_drop_m0", m0_grant, 1);
    m0_req = 0;
    tick();
`endif

    // M0 write to unmapped 0x0500
    m0_req = 1; m0_wr = 1; m0_address = 16'h0500; m0_dout = 32'hDEAD_BEEF; s_sel = 5'b00000;
    #1;
    check("wr_s_wr", s_wr, 1);
    check("wr_s_address", s_address, 32'h0500);
    check("wr_s_din", s_din, 32'hDEAD_BEEF);
    check("wr_err_not_yet", bus_err, 0);
    tick();
    check("wr_bus_err", bus_err, 1);
    check("wr_m_din", m_din, 0);
    tick();
    check("wr_bus_err_repeat", bus_err, 1);
    // Mapped write: no read data returns
    s_sel = 5'b01000;
    tick();
    check("wr_mapped_no_err", bus_err, 0);
    check("wr_mapped_mdin", m_din, 0);
    // Faulty decoder select on a read
    m0_wr = 0; s_sel = 5'b00110;
    tick();
    check("nonhot_mdin", m_din, 0);
    check("nonhot_no_err", bus_err, 0);
    m0_req = 0; s_sel = 5'b00000;
    #1;
    check("idle_s_wr", s_wr, 0);
    tick();
    check("idle_bus_err", bus_err, 0);

    // Reset in the middle of an M1 read
    m1_req = 1; m1_wr = 0; m1_address = 16'h0220; s_sel = 5'b00100;
    tick();
    check("mid_m1_grant", m1_grant, 1);
    tick();
    check("mid_m1_mdin", m_din, 32'hA5A5_0002);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_m0_grant", m0_grant, 1);
    check("async_m1_grant", m1_grant, 0);
    check("async_m_din", m_din, 0);
    check("async_bus_err", bus_err, 0);
    m1_req = 0; s_sel = 5'b00000;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_m0_grant", m0_grant, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Front end of the system bus: two masters share one slave-side bus.
  - M0 is the testbench/CPU port.
  - M1 is the DMAC master port.
- Arbitrates between them with a registered fixed-priority FSM and muxes the granted master's address/write/data onto the bus.
- The bus address feeds the address decoder. The decoder's 5-bit one-hot select returns here to steer the read-data mux back to the masters.
- Also flags accesses to unmapped addresses.

Parameters:
- DATA_W, 32, bus data width.
- ADDR_W, 16, bus address width (upper 8 bits decoded downstream).

Ports:
- clk  input  1  bus clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- m0_req  input  1  M0 bus request, level, held for the whole tenure.
- m0_wr  input  1  M0 write strobe (1 = write, 0 = read).
- m0_address  input  ADDR_W  M0 address.
- m0_dout  input  DATA_W  M0 write data.
- m1_req  input  1  M1 (DMAC) bus request.
- m1_wr  input  1  M1 write strobe.
- m1_address  input  ADDR_W  M1 address.
- m1_dout  input  DATA_W  M1 write data.
- m0_grant  output  1  M0 owns bus (registered).
- m1_grant  output  1  M1 owns bus (registered).
- s_address  output  ADDR_W  bus address to decoder and slaves.
- s_wr  output  1  bus write strobe.
- s_din  output  DATA_W  bus write data to slaves.
- s_sel  input  5  one-hot slave select from decoder; bit4 = s0 ... bit0 = s4.
- s0_dout..s4_dout  input  DATA_W each  slave read data.
- m_din  output  DATA_W  read data returned to both masters.
- bus_err  output  1  one-cycle pulse: previous cycle's access hit no slave.

Behaviour:
- Reset (async, reset_n=0):
  - state = GRANT_M0; m0_grant=1, m1_grant=0.
  - Internal sel_q=5'b00000.
  - bus_err=0, m_din=0.
  - Takes effect immediately, mid-transfer included; any in-flight DMAC tenure is dropped.
- FSM states GRANT_M0 and GRANT_M1, one-hot grants registered directly from state; exactly one grant is high at all times.
- GRANT_M0 transitions:
  - m0_req=1 -> stay.
  - m0_req=0 and m1_req=1 -> GRANT_M1.
  - else stay (M0 parks the bus).
- GRANT_M1 transitions:
  - m1_req=1 -> stay (no preemption by M0 unless the optional feature is enabled).
  - m1_req=0 -> GRANT_M0.
- Grant latency: request sampled at edge N, grant high after edge N; one bubble cycle on every handover.
- Simultaneous m0_req=m1_req=1 from GRANT_M0 -> M0 keeps the bus.
- Bus mux (combinational from grant):
  - Granted master's address and dout drive s_address and s_din.
  - s_wr = granted master's wr AND granted master's req; s_wr=0 when the owner is not requesting.
  - s_address and s_din still follow the owner when idle.
- Access valid: acc = granted master's req.
- Read path, latency 1 (slaves have registered read data):
  - sel_q <= s_sel & {5{acc & ~s_wr}} each edge.
  - m_din = s0_dout when sel_q[4], s1 when [3], s2 [2], s3 [1], s4 [0], else 0. Combinational from sel_q, no priority needed (one-hot).
- bus_err:
  - Registered: bus_err <= acc & (s_sel == 5'b00000).
  - Covers reads and writes; high exactly one cycle after the bad access cycle, repeats each cycle while the bad access persists.
- Non-one-hot s_sel (decoder fault) -> m_din = 0.

Optional Feature:
- Macro ARB_TENURE_LIMIT_EN.
- Defined:
  - Adds parameter MAX_TENURE (default 16) and a tenure counter that clears on every grant change.
  - The counter increments each cycle in GRANT_M1 while m1_req=1.
  - When count reaches MAX_TENURE-1 and m0_req=1, force GRANT_M0 at the next edge; M1 must re-request.
  - The counter holds at saturation if m0_req=0.
- Undefined: no counter and no MAX_TENURE; M1 holds the bus until it drops m1_req.

Test Plan:
- Reset release with both req=0 -> m0_grant=1, m1_grant=0, bus_err=0, m_din=0.
- m0_req=0, m1_req=1, m1_address=16'h0210, m1_wr=0:
  - Cycle 1: m1_grant=1.
  - s_address=16'h0210.
  - With s_sel=5'b00100 and s2_dout=32'hA5A5_0002, m_din=32'hA5A5_0002 one cycle later.
- Both req=1 from reset -> M0 holds. Drop m0_req -> m1_grant next edge. Raise m0_req during M1 tenure -> no switch until m1_req=0.
- M0 write to 16'h0500 with s_sel=5'b00000 -> s_wr=1 that cycle, bus_err=1 exactly one cycle later, m_din stays 0.
- reset_n asserted mid M1 read -> grants return to M0 immediately, sel_q cleared, m_din=0 asynchronously.
- ARB_TENURE_LIMIT_EN with MAX_TENURE=4: M1 continuously requesting, M0 requests -> m0_grant rises after the 4th M1 cycle. Without the macro, M1 keeps the bus indefinitely.
